// File: rtl/barrel_shift_arbiter_if.sv
// Requester, shifter and response signals shared by the barrel-shift arbiter
// (slave side) and its clients plus the shifter itself (master side).
interface barrel_shift_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_data;
    logic [2:0] req0_shamt;
    logic       req0_lr;
    logic       req0_al;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_data;
    logic [2:0] req1_shamt;
    logic       req1_lr;
    logic       req1_al;
    logic [7:0] sh_din;
    logic [2:0] sh_shamt;
    logic       sh_lr;
    logic       sh_al;
    logic [7:0] sh_dout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic       busy;

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_lr, req0_al,
        output req0_ready,
        input  req1_valid, req1_data, req1_shamt, req1_lr, req1_al,
        output req1_ready,
        output sh_din, sh_shamt, sh_lr, sh_al,
        input  sh_dout,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_lr, req0_al,
        input  req0_ready,
        output req1_valid, req1_data, req1_shamt, req1_lr, req1_al,
        input  req1_ready,
        input  sh_din, sh_shamt, sh_lr, sh_al,
        output sh_dout,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Two-way round-robin sequencer sharing one combinational barrel shifter:
// accept a request, hold the shifter operands SH_LAT cycles, return the result.
module barrel_shift_arbiter #(
    parameter int unsigned SH_LAT = 32'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    barrel_shift_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SH_LAT - 32'd1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic       last_grant_r;
    logic [7:0] sh_din_r;
    logic [2:0] sh_shamt_r;
    logic       sh_lr_r;
    logic       sh_al_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;
    logic       rsp_id_r;
    logic       busy_r;
    logic       grant0_s;
    logic       grant1_s;
    logic       accept_s;
    logic       hold_done_s;

    // Round-robin grant: a tie goes to the requester not served last time.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0_s = 1'b1;
            end else if (bus.req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s    = grant0_s | grant1_s;
    assign hold_done_s = (cnt_r == LAST_CNT);

    // Next-state decode for the IDLE -> DRIVE -> RESP sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = DRIVE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRIVE: begin
                if (hold_done_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = DRIVE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, operand, counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            last_grant_r <= 1'b1;
            sh_din_r     <= 8'd0;
            sh_shamt_r   <= 3'd0;
            sh_lr_r      <= 1'b0;
            sh_al_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= 8'd0;
            rsp_id_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sh_din_r     <= grant1_s ? bus.req1_data  : bus.req0_data;
                        sh_shamt_r   <= grant1_s ? bus.req1_shamt : bus.req0_shamt;
                        sh_lr_r      <= grant1_s ? bus.req1_lr    : bus.req0_lr;
                        sh_al_r      <= grant1_s ? bus.req1_al    : bus.req0_al;
                        rsp_id_r     <= grant1_s;
                        last_grant_r <= grant1_s;
                        cnt_r        <= 4'd0;
                    end
                end
                DRIVE: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (hold_done_s) begin
                        rsp_data_r <= bus.sh_dout;
                    end
                end
                RESP: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.sh_din     = sh_din_r;
    assign bus.sh_shamt   = sh_shamt_r;
    assign bus.sh_lr      = sh_lr_r;
    assign bus.sh_al      = sh_al_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.busy       = busy_r;
endmodule
